// File: rtl/crc_arb_pkg.sv
// Shared types for the CRC job arbiter: FSM states, profile record and a width helper.
package crc_arb_pkg;

  // Profile fields are stored at this width; keep CRC_WIDTH at or below it.
  localparam int CRC_MAX_W = 16;

  typedef logic [CRC_MAX_W-1:0] crc_t;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    BUSY,
    CAPTURE,
    RESP
  } arb_state_t;

  typedef struct packed {
    crc_t poly;
    crc_t init;
    crc_t finalXor;
    logic refIn;
    logic refOut;
  } profile_t;

  // Index width for a table of the given depth, never narrower than one bit.
  function automatic int clog2(input int value);
    int w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/crc_rr_arbiter.sv
// Round-robin arbiter: grants the first request strictly after the last winner.
module crc_rr_arbiter
  import crc_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IW      = clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rstN,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      grant_idx,
  output logic               any_req
);

  logic [IW-1:0] ptr;
  logic          found;

  // Scan from the slot after the pointer, wrapping, so the last winner comes last.
  always_comb begin
    int slot;
    slot      = 0;
    found     = 1'b0;
    grant_idx = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      slot = (int'(ptr) + i) % NUM_REQ;
      if (!found && req[slot]) begin
        found     = 1'b1;
        grant_idx = IW'(slot);
      end
    end
    grant   = found ? (NUM_REQ'(1) << grant_idx) : '0;
    any_req = |req;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      ptr <= IW'(NUM_REQ - 1);
    end else if (advance && any_req) begin
      ptr <= grant_idx;
    end
  end

endmodule

// File: rtl/crc_job_arbiter.sv
// Shares one CRC engine between NUM_REQ requesters with tagged responses.
// Define CRC_ARB_TIMEOUT_EN to bound the engine wait and flag rspErr on expiry.
module crc_job_arbiter
  import crc_arb_pkg::*;
#(
  parameter  int NUM_REQ   = 4,
  parameter  int NUM_PROF  = 4,
  parameter  int CRC_WIDTH = 16,
  parameter  int DWIDTH    = 32,
  parameter  int TIMEOUT   = 15,
  localparam int PW        = clog2(NUM_PROF),
  localparam int IW        = clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rstN,
  input  logic [NUM_REQ-1:0]      reqValid,
  input  logic [NUM_REQ*DWIDTH-1:0] reqData,
  input  logic [NUM_REQ*PW-1:0]   reqProf,
  output logic [NUM_REQ-1:0]      reqReady,
  input  logic                    cfgWe,
  input  logic [PW-1:0]           cfgAddr,
  input  logic [CRC_WIDTH-1:0]    cfgPoly,
  input  logic [CRC_WIDTH-1:0]    cfgInit,
  input  logic [CRC_WIDTH-1:0]    cfgFinalXor,
  input  logic                    cfgRefIn,
  input  logic                    cfgRefOut,
  output logic                    engEn,
  output logic [DWIDTH-1:0]       engData,
  output logic [CRC_WIDTH-1:0]    engPoly,
  output logic [CRC_WIDTH-1:0]    engInit,
  output logic [CRC_WIDTH-1:0]    engFinalXor,
  output logic                    engRefIn,
  output logic                    engRefOut,
  input  logic [CRC_WIDTH-1:0]    engCrc,
  input  logic                    engReady,
  output logic                    rspValid,
  output logic [IW-1:0]           rspId,
  output logic [CRC_WIDTH-1:0]    rspCrc,
  output logic                    rspErr,
  input  logic                    rspReady
);

  arb_state_t          state;
  profile_t            prof_tab [NUM_PROF];
  profile_t            win_prof;
  logic [DWIDTH-1:0]   win_data;
  logic [NUM_REQ-1:0]  grant;
  logic [IW-1:0]       grant_idx;
  logic                any_req;
  logic                advance;

  assign advance = (state == IDLE);

  crc_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk       (clk),
    .rstN      (rstN),
    .req       (reqValid),
    .advance   (advance),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_req   (any_req)
  );

  assign reqReady = advance ? grant : '0;
  assign win_data = reqData[grant_idx*DWIDTH +: DWIDTH];
  assign win_prof = prof_tab[reqProf[grant_idx*PW +: PW]];

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int i = 0; i < NUM_PROF; i++) prof_tab[i] <= '0;
    end else if (cfgWe) begin
      prof_tab[cfgAddr] <= '{poly:     crc_t'(cfgPoly),
                             init:     crc_t'(cfgInit),
                             finalXor: crc_t'(cfgFinalXor),
                             refIn:    cfgRefIn,
                             refOut:   cfgRefOut};
    end
  end

`ifdef CRC_ARB_TIMEOUT_EN
  localparam int TW = clog2(TIMEOUT + 1);
  logic [TW-1:0] wait_cnt;
  logic          rsp_err;
  assign rspErr = rsp_err;
`else
  assign rspErr = 1'b0;
`endif

  // The eng* outputs are the job snapshot: loaded at grant, held until the next grant.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state       <= IDLE;
      engEn       <= 1'b0;
      engData     <= '0;
      engPoly     <= '0;
      engInit     <= '0;
      engFinalXor <= '0;
      engRefIn    <= 1'b0;
      engRefOut   <= 1'b0;
      rspValid    <= 1'b0;
      rspId       <= '0;
      rspCrc      <= '0;
`ifdef CRC_ARB_TIMEOUT_EN
      wait_cnt    <= '0;
      rsp_err     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            engData     <= win_data;
            engPoly     <= CRC_WIDTH'(win_prof.poly);
            engInit     <= CRC_WIDTH'(win_prof.init);
            engFinalXor <= CRC_WIDTH'(win_prof.finalXor);
            engRefIn    <= win_prof.refIn;
            engRefOut   <= win_prof.refOut;
            rspId       <= grant_idx;
            engEn       <= 1'b1;
            state       <= LAUNCH;
          end
        end
        LAUNCH: begin
          engEn <= 1'b0;
          state <= BUSY;
        end
        BUSY: begin
`ifdef CRC_ARB_TIMEOUT_EN
          wait_cnt <= '0;
`endif
          state <= CAPTURE;
        end
        CAPTURE: begin
          if (engReady) begin
            rspCrc   <= engCrc;
            rspValid <= 1'b1;
`ifdef CRC_ARB_TIMEOUT_EN
            rsp_err  <= 1'b0;
`endif
            state    <= RESP;
          end
`ifdef CRC_ARB_TIMEOUT_EN
          else if (wait_cnt == TW'(TIMEOUT - 1)) begin
            rspCrc   <= '0;
            rsp_err  <= 1'b1;
            rspValid <= 1'b1;
            state    <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        RESP: begin
          if (rspReady) begin
            rspValid <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_crc_job_arbiter.sv
// Directed self-checking bench for crc_job_arbiter; the engine is modelled by driving engCrc/engReady.
module tb_crc_job_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int NUM_PROF  = 4;
  localparam int CRC_WIDTH = 16;
  localparam int DWIDTH    = 32;
  localparam int TIMEOUT   = 15;

  logic         clk = 1'b0;
  logic         rstN;
  logic [3:0]   reqValid;
  logic [127:0] reqData;
  logic [7:0]   reqProf;
  logic [3:0]   reqReady;
  logic         cfgWe;
  logic [1:0]   cfgAddr;
  logic [15:0]  cfgPoly, cfgInit, cfgFinalXor;
  logic         cfgRefIn, cfgRefOut;
  logic         engEn;
  logic [31:0]  engData;
  logic [15:0]  engPoly, engInit, engFinalXor;
  logic         engRefIn, engRefOut;
  logic [15:0]  engCrc;
  logic         engReady;
  logic         rspValid;
  logic [1:0]   rspId;
  logic [15:0]  rspCrc;
  logic         rspErr;
  logic         rspReady;

  int compares   = 0;
  int mismatches = 0;

  always #5 clk = ~clk;

  crc_job_arbiter #(
    .NUM_REQ(NUM_REQ), .NUM_PROF(NUM_PROF), .CRC_WIDTH(CRC_WIDTH),
    .DWIDTH(DWIDTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rstN(rstN),
    .reqValid(reqValid), .reqData(reqData), .reqProf(reqProf), .reqReady(reqReady),
    .cfgWe(cfgWe), .cfgAddr(cfgAddr), .cfgPoly(cfgPoly), .cfgInit(cfgInit),
    .cfgFinalXor(cfgFinalXor), .cfgRefIn(cfgRefIn), .cfgRefOut(cfgRefOut),
    .engEn(engEn), .engData(engData), .engPoly(engPoly), .engInit(engInit),
    .engFinalXor(engFinalXor), .engRefIn(engRefIn), .engRefOut(engRefOut),
    .engCrc(engCrc), .engReady(engReady),
    .rspValid(rspValid), .rspId(rspId), .rspCrc(rspCrc), .rspErr(rspErr),
    .rspReady(rspReady)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compares++;
    assert (obs === exp) else begin
      mismatches++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] valid, input logic [7:0] prof);
    reqValid = valid;
    reqProf  = prof;
    #1;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic setCfg(input logic [1:0] addr, input logic [15:0] poly, input logic [15:0] init,
                        input logic [15:0] fx, input logic ri, input logic ro);
    cfgAddr = addr; cfgPoly = poly; cfgInit = init; cfgFinalXor = fx;
    cfgRefIn = ri; cfgRefOut = ro;
  endtask

  initial begin
    rstN = 1'b0; reqValid = '0; reqProf = '0; cfgWe = 1'b0;
    setCfg(2'd0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) reqData[i*32 +: 32] = 32'hA000_0000 + i;
    engCrc = 16'hABCD; engReady = 1'b1; rspReady = 1'b1;

    #12;
    checkOutput("rst_reqReady", reqReady, 0);
    checkOutput("rst_engEn", engEn, 0);
    checkOutput("rst_rspValid", rspValid, 0);
    checkOutput("rst_rspErr", rspErr, 0);
    checkOutput("rst_rspId", rspId, 0);
    checkOutput("rst_rspCrc", rspCrc, 0);
    checkOutput("rst_engPoly", engPoly, 0);
    rstN = 1'b1;
    step(1);

    // Profile 0: plain CRC-16 poly 8005; profile 1: reflected variant.
    setCfg(2'd0, 16'h8005, 16'h0000, 16'h0000, 1'b0, 1'b0); cfgWe = 1'b1; step(1);
    setCfg(2'd1, 16'h3D65, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1); step(1);
    cfgWe = 1'b0;

    // Fairness: all requesters valid, pointer starts behind requester 0.
    applyStimulus(4'hF, 8'h00);
    for (int k = 0; k < 8; k++) begin
      checkOutput($sformatf("fair_grant%0d", k), reqReady, 32'd1 << (k % 4));
      step(4);
      checkOutput($sformatf("fair_id%0d", k), rspId, k % 4);
      step(1);
    end
    applyStimulus(4'h0, 8'h00);

    // Single request from requester 2 with the nominal engine.
    reqData[64 +: 32] = 32'h3132_3334;
    applyStimulus(4'b0100, 8'h00);
    checkOutput("single_grant", reqReady, 4'b0100);
    step(1);
    applyStimulus(4'h0, 8'h00);
    checkOutput("single_engEn_T1", engEn, 1);
    checkOutput("single_engData", engData, 32'h3132_3334);
    checkOutput("single_engPoly", engPoly, 16'h8005);
    checkOutput("single_engRefIn", engRefIn, 0);
    checkOutput("single_noReady", reqReady, 0);
    step(1);
    checkOutput("single_engEn_T2", engEn, 0);
    step(1);
    checkOutput("single_rspValid_T3", rspValid, 0);
    step(1);
    checkOutput("single_rspValid_T4", rspValid, 1);
    checkOutput("single_rspId", rspId, 2);
    checkOutput("single_rspCrc", rspCrc, 16'hABCD);
    checkOutput("single_rspErr", rspErr, 0);
    step(1);
    checkOutput("single_rspDone", rspValid, 0);

    // Snapshot isolation: profile 1 rewritten while its job is BUSY.
    applyStimulus(4'b0010, 8'h04);
    checkOutput("snap_grant", reqReady, 4'b0010);
    step(1);
    applyStimulus(4'h0, 8'h04);
    checkOutput("snap_launchPoly", engPoly, 16'h3D65);
    step(1);
    setCfg(2'd1, 16'h1021, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1); cfgWe = 1'b1;
    step(1);
    cfgWe = 1'b0;
    checkOutput("snap_capturePoly", engPoly, 16'h3D65);
    step(1);
    checkOutput("snap_respPoly", engPoly, 16'h3D65);
    checkOutput("snap_rspValid", rspValid, 1);
    step(1);
    // Next profile-1 job, with a write landing on the grant edge itself.
    setCfg(2'd1, 16'h0589, 16'h0000, 16'h0000, 1'b0, 1'b0); cfgWe = 1'b1;
    applyStimulus(4'b0010, 8'h04);
    checkOutput("snap2_grant", reqReady, 4'b0010);
    step(1);
    cfgWe = 1'b0;
    applyStimulus(4'h0, 8'h04);
    checkOutput("snap2_newPoly", engPoly, 16'h1021);
    checkOutput("snap2_init", engInit, 16'hFFFF);
    checkOutput("snap2_refOut", engRefOut, 1);
    step(4);

    // Backpressure: response held while requester 0 waits.
    reqData[96 +: 32] = 32'hDEAD_BEEF;
    engCrc = 16'h1234; rspReady = 1'b0;
    applyStimulus(4'b1000, 8'h00);
    checkOutput("bp_grant", reqReady, 4'b1000);
    step(1);
    applyStimulus(4'b0001, 8'h00);
    step(3);
    engCrc = 16'h5555;
    for (int k = 0; k < 10; k++) begin
      checkOutput($sformatf("bp_valid%0d", k), rspValid, 1);
      checkOutput($sformatf("bp_crc%0d", k), rspCrc, 16'h1234);
      checkOutput($sformatf("bp_id%0d", k), rspId, 3);
      checkOutput($sformatf("bp_noReady%0d", k), reqReady, 0);
      step(1);
    end
    rspReady = 1'b1;
    #1;
    checkOutput("bp_stillValid", rspValid, 1);
    step(1);
    checkOutput("bp_released", rspValid, 0);
    checkOutput("bp_nextGrant", reqReady, 4'b0001);

    // Reset while the requester-0 job is stuck in CAPTURE.
    engReady = 1'b0;
    step(1);
    applyStimulus(4'h0, 8'h00);
    checkOutput("rstjob_engData", engData, 32'hA000_0000);
    step(5);
    checkOutput("rstjob_waiting", rspValid, 0);
    rstN = 1'b0;
    #1;
    checkOutput("rstjob_engEn", engEn, 0);
    checkOutput("rstjob_rspValid", rspValid, 0);
    checkOutput("rstjob_engData0", engData, 0);
    checkOutput("rstjob_engPoly0", engPoly, 0);
    rstN = 1'b1; engReady = 1'b1;
    applyStimulus(4'hF, 8'h01);
    checkOutput("rstjob_grant0", reqReady, 4'b0001);
    step(1);
    applyStimulus(4'h0, 8'h00);
    checkOutput("rstjob_profCleared", engPoly, 0);
    checkOutput("rstjob_initCleared", engInit, 0);
    step(4);

`ifdef CRC_ARB_TIMEOUT_EN
    engReady = 1'b0; engCrc = 16'h7777;
    applyStimulus(4'b0010, 8'h00);
    step(1);
    applyStimulus(4'h0, 8'h00);
    step(2 + TIMEOUT - 1);
    checkOutput("to_notYet", rspValid, 0);
    step(1);
    checkOutput("to_valid", rspValid, 1);
    checkOutput("to_err", rspErr, 1);
    checkOutput("to_crc", rspCrc, 0);
    engReady = 1'b1;
    step(1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mismatches);
    $finish;
  end

endmodule

// File: doc/crc_job_arbiter.md
# crc_job_arbiter

Shares one parallel CRC engine between `NUM_REQ` requesters. Each requester submits a data word and a profile index. A round-robin arbiter grants one job at a time. The block drives the engine from a snapshot of a small profile table (polynomial, init XOR, reflect-in/out, final XOR), waits for the engine result, and returns it on a single tagged response channel.

## Interface
- `NUM_REQ`, 4, number of requesters (2..8)
- `NUM_PROF`, 4, number of CRC profiles in the table
- `CRC_WIDTH`, 16, CRC width
- `DWIDTH`, 32, data word width, multiple of 8, ≥ `CRC_WIDTH`
- `TIMEOUT`, 15, engine wait limit in cycles (used only with `CRC_ARB_TIMEOUT_EN`)
- `clk` in 1 system clock
- `rstN` in 1 asynchronous, active-low reset
- `reqValid` in `NUM_REQ` per-requester job request
- `reqData` in `NUM_REQ*DWIDTH` packed job data; requester i uses slice i
- `reqProf` in `NUM_REQ*PW` packed profile index, `PW = clog2(NUM_PROF)`
- `reqReady` out `NUM_REQ` one-hot acceptance
- `cfgWe` in 1 profile write strobe
- `cfgAddr` in `PW` profile index to write
- `cfgPoly`, `cfgInit`, `cfgFinalXor` in `CRC_WIDTH` each: profile fields
- `cfgRefIn`, `cfgRefOut` in 1 each: profile reflect flags
- `engEn` out 1 engine start pulse
- `engData` out `DWIDTH` engine data
- `engPoly`, `engInit`, `engFinalXor` out `CRC_WIDTH` engine config
- `engRefIn`, `engRefOut` out 1 engine reflect controls
- `engCrc` in `CRC_WIDTH` engine result
- `engReady` in 1 engine idle/result-valid
- `rspValid` out 1 response valid
- `rspId` out `clog2(NUM_REQ)` index of the requester that owns the response
- `rspCrc` out `CRC_WIDTH` captured CRC
- `rspErr` out 1 engine timeout flag
- `rspReady` in 1 response accept

## Operation
- **Reset values:**
  - `reqReady`, `engEn`, `rspValid`, `rspErr` = 0.
  - `rspId`, `rspCrc`, all `eng*` config/data outputs, and all profile entries = 0.
  - Round-robin pointer = `NUM_REQ-1`, so requester 0 has first priority.
  - FSM starts in IDLE.
- **Profile writes:** `cfgWe` writes entry `cfgAddr` at the clock edge, in any state. Writes never disturb a granted job, because the job runs from a snapshot.
- **FSM states:**
  - IDLE: if any `reqValid`, the arbiter picks the first set bit strictly after the pointer (wrapping). The winner's `reqReady` is asserted combinationally this cycle. Data, profile snapshot and id are registered, the pointer is updated to the winner, and the FSM goes to LAUNCH. No `reqValid` means stay in IDLE with `reqReady` = 0.
  - LAUNCH: `engEn` = 1 for exactly one cycle. Go to BUSY.
  - BUSY: `engReady` is ignored (the engine is loading). Go to CAPTURE.
  - CAPTURE: on `engReady` = 1, register `engCrc` into `rspCrc`, set `rspErr` = 0 and go to RESP. Otherwise stay.
  - RESP: `rspValid` = 1 and held stable until `rspReady` = 1, then return to IDLE.
- **Engine outputs:** `eng*` data and config outputs hold the snapshot from LAUNCH through RESP. This is required because the engine applies final XOR combinationally on its output.
- **Boundary conditions:**
  - A requester dropping `reqValid` before grant is legal.
  - `reqValid` is never consumed without a `reqReady` pulse.
  - If all requesters are valid continuously, grants rotate 0,1,2,3,0…
  - A profile written in the same cycle as a grant: the snapshot takes the old value.
  - Reset mid-job: outputs return to reset values at once and the job is dropped with no response.

## Timing
- Grant at cycle T. `engEn` at T+1. Capture at T+3. `rspValid` at T+4, given a nominal engine.
- Throughput: one job per 5 cycles with `rspReady` held high.
- `reqReady` is combinational from `reqValid` and state. All other outputs are registered.

## Configuration
- **`CRC_ARB_TIMEOUT_EN` defined:** a counter runs in CAPTURE. After `TIMEOUT` cycles without `engReady`, the FSM goes to RESP with `rspErr` = 1 and `rspCrc` = 0.
- **Not defined:** CAPTURE waits indefinitely, `rspErr` is tied to 0, and no counter is built.

## Structure
- Package `crc_arb_pkg` holds:
  - FSM state enum (IDLE, LAUNCH, BUSY, CAPTURE, RESP)
  - profile struct (poly, init, finalXor, refIn, refOut)
  - `clog2` function
- Sub-module `crc_rr_arbiter`: a `NUM_REQ`-wide round-robin arbiter with pointer register, taking request vector and advance enable, producing one-hot grant and index.

## Test plan
- **Single request:** profile 0 = poly `16'h8005`, init 0, final XOR 0, no reflect. Requester 2 sends `32'h31323334`. Expected: `reqReady[2]` pulses, `engEn` fires at T+1, `rspValid` at T+4 with `rspId` = 2 and `rspCrc` = the engine's returned value.
- **Fairness:** all 4 requesters valid for 8 jobs. Expected grant order 0,1,2,3,0,1,2,3 with no requester granted twice in a row.
- **Snapshot isolation:** write profile 1 poly `16'h1021` during job BUSY. Expected: `engPoly` stays at the old value until RESP exits; the next profile-1 job drives `16'h1021`.
- **Backpressure:** hold `rspReady` = 0 for 10 cycles. Expected: `rspValid`, `rspId`, `rspCrc` stable; no new `reqReady`; FSM advances one cycle after `rspReady` rises.
- **Timeout (`CRC_ARB_TIMEOUT_EN`):** hold `engReady` = 0. Expected: `rspErr` = 1 and `rspCrc` = 0 exactly `TIMEOUT` cycles after CAPTURE entry.
- **Reset mid-job:** assert `rstN` low in CAPTURE. Expected: `rspValid`/`engEn` = 0 immediately, profiles cleared, next grant goes to requester 0.
